pipe_control_unit: RTL

Registered, handshaked decode/control stage for the RV32 pipeline. It sits between the IF/ID register and the EX stage. Each cycle it decodes one 32-bit instruction into the main control word (reg_write, mem_to_reg, mem_read, mem_write, alu_src, alu_op, branch) plus jump, register indices and an illegal flag. It holds the result in an ID/EX output register with valid/ready flow control. It also detects load-use hazards and inserts a one-cycle bubble, and it supports a synchronous flush for branch/jump redirects.

---
 rtl/pipe_control_unit_if.sv | 39 +++
 rtl/pipe_control_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit_if.sv
// Handshake and control-word bundle for the decode/control stage.
// master: upstream/downstream environment (drives instruction, in_valid, flush, out_ready)
// slave : pipe_control_unit (drives in_ready, out_valid and the registered control word)
interface pipe_control_unit_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned AOP_W = 2;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    instruction;
    logic               out_valid;
    logic               out_ready;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               branch;
    logic               jump;
    logic [AOP_W-1:0]   alu_op;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic               illegal;

    modport master (
        output flush, in_valid, instruction, out_ready,
        input  in_ready, out_valid, reg_write, mem_to_reg, mem_read, mem_write,
               alu_src, branch, jump, alu_op, rd, rs1, rs2, illegal
    );

    modport slave (
        input  flush, in_valid, instruction, out_ready,
        output in_ready, out_valid, reg_write, mem_to_reg, mem_read, mem_write,
               alu_src, branch, jump, alu_op, rd, rs1, rs2, illegal
    );
endinterface

// File: rtl/pipe_control_unit.sv
// RV32 decode/control stage with an ID/EX output register, valid/ready flow
// control, single-bubble load-use stall and synchronous flush.
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - pipe_control_unit_if.slave: flush, in_valid/in_ready/instruction,
//           out_valid/out_ready and the registered control word
//           (reg_write, mem_to_reg, mem_read, mem_write, alu_src, branch,
//           jump, alu_op, rd, rs1, rs2, illegal). in_ready is combinational.
module pipe_control_unit #(
    parameter bit SUPPORT_M         = 1'b1,
    parameter bit X0_WRITE_SUPPRESS = 1'b1,
    parameter bit HAZARD_EN         = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_control_unit_if.slave   bus
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned AOP_W = 2;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F7_W  = 7;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [F7_W-1:0]  F7_MULDIV  = 7'b0000001;

    localparam logic [AOP_W-1:0] AOP_ADD = 2'b00;
    localparam logic [AOP_W-1:0] AOP_BR  = 2'b01;
    localparam logic [AOP_W-1:0] AOP_R   = 2'b10;
    localparam logic [AOP_W-1:0] AOP_I   = 2'b11;

    logic [OPC_W-1:0] opcode;
    logic [F7_W-1:0]  funct7;
    logic [REG_W-1:0] rd_d;
    logic [REG_W-1:0] rs1_d;
    logic [REG_W-1:0] rs2_d;

    logic             reg_write_d;
    logic             mem_to_reg_d;
    logic             mem_read_d;
    logic             mem_write_d;
    logic             alu_src_d;
    logic             branch_d;
    logic             jump_d;
    logic [AOP_W-1:0] alu_op_d;
    logic             illegal_d;
    logic             uses_rs1_d;
    logic             uses_rs2_d;

    logic             out_valid_q;
    logic             reg_write_q;
    logic             mem_to_reg_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic             alu_src_q;
    logic             branch_q;
    logic             jump_q;
    logic [AOP_W-1:0] alu_op_q;
    logic [REG_W-1:0] rd_q;
    logic [REG_W-1:0] rs1_q;
    logic [REG_W-1:0] rs2_q;
    logic             illegal_q;
    logic             ex_load_v_q;
    logic [REG_W-1:0] ex_load_rd_q;

    logic             stall_c;
    logic             in_ready_c;
    logic             accept_c;
    logic             xfer_c;

    assign opcode = bus.instruction[6:0];
    assign funct7 = bus.instruction[31:25];
    assign rd_d   = bus.instruction[11:7];
    assign rs1_d  = bus.instruction[19:15];
    assign rs2_d  = bus.instruction[24:20];

    // Opcode decode into the main control word and register usage
    always_comb begin
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        alu_op_d     = AOP_ADD;
        illegal_d    = 1'b0;
        uses_rs1_d   = 1'b0;
        uses_rs2_d   = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (!SUPPORT_M && funct7 == F7_MULDIV) begin
                    illegal_d = 1'b1;
                end else begin
                    reg_write_d = 1'b1;
                    alu_op_d    = AOP_R;
                    uses_rs1_d  = 1'b1;
                    uses_rs2_d  = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op_d    = AOP_I;
                uses_rs1_d  = 1'b1;
            end
            OPC_LOAD: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
                mem_read_d   = 1'b1;
                alu_src_d    = 1'b1;
                uses_rs1_d   = 1'b1;
            end
            OPC_STORE: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
                uses_rs1_d  = 1'b1;
                uses_rs2_d  = 1'b1;
            end
            OPC_BRANCH: begin
                branch_d   = 1'b1;
                alu_op_d   = AOP_BR;
                uses_rs1_d = 1'b1;
                uses_rs2_d = 1'b1;
            end
            OPC_JAL: begin
                reg_write_d = 1'b1;
                jump_d      = 1'b1;
            end
            OPC_JALR: begin
                reg_write_d = 1'b1;
                jump_d      = 1'b1;
                alu_src_d   = 1'b1;
                uses_rs1_d  = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
        if (X0_WRITE_SUPPRESS && rd_d == REG_W'(0)) begin
            reg_write_d = 1'b0;
        end
    end

    // Load-use: the incoming word reads the register a just-transferred load writes
    assign stall_c = HAZARD_EN && ex_load_v_q && bus.in_valid &&
                     ((uses_rs1_d && rs1_d == ex_load_rd_q) ||
                      (uses_rs2_d && rs2_d == ex_load_rd_q));

    assign in_ready_c = !bus.flush && !stall_c && (!out_valid_q || bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;
    assign xfer_c     = out_valid_q && bus.out_ready;

    // ID/EX output register and one-cycle load tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            alu_op_q     <= AOP_ADD;
            rd_q         <= REG_W'(0);
            rs1_q        <= REG_W'(0);
            rs2_q        <= REG_W'(0);
            illegal_q    <= 1'b0;
            ex_load_v_q  <= 1'b0;
            ex_load_rd_q <= REG_W'(0);
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            ex_load_v_q <= 1'b0;
        end else begin
            ex_load_v_q <= xfer_c && mem_read_q && (rd_q != REG_W'(0));
            if (xfer_c) begin
                ex_load_rd_q <= rd_q;
            end
            if (accept_c) begin
                out_valid_q  <= 1'b1;
                reg_write_q  <= reg_write_d;
                mem_to_reg_q <= mem_to_reg_d;
                mem_read_q   <= mem_read_d;
                mem_write_q  <= mem_write_d;
                alu_src_q    <= alu_src_d;
                branch_q     <= branch_d;
                jump_q       <= jump_d;
                alu_op_q     <= alu_op_d;
                rd_q         <= rd_d;
                rs1_q        <= rs1_d;
                rs2_q        <= rs2_d;
                illegal_q    <= illegal_d;
            end else if (xfer_c) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.mem_to_reg = mem_to_reg_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.alu_src    = alu_src_q;
    assign bus.branch     = branch_q;
    assign bus.jump       = jump_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rd         = rd_q;
    assign bus.rs1        = rs1_q;
    assign bus.rs2        = rs2_q;
    assign bus.illegal    = illegal_q;
endmodule
